// File: rtl/fc_argmax_classifier.sv
// fc_argmax_classifier: collects NUM_CLASSES signed scores, reports argmax with a done pulse
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start                 begin an inference (IDLE or DONE only)
//   score_valid/score     score handshake input, class order 0..NUM_CLASSES-1
//   score_ready, busy     high while collecting
//   done                  one-cycle pulse when class_idx/max_score update
//   class_idx, max_score  winning index and its score
//   rd_addr/rd_data       registered score-buffer readout
module fc_argmax_classifier #(
    parameter int IN_WIDTH    = 32,
    parameter int NUM_CLASSES = 10,
    parameter int IDX_WIDTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        score_valid,
    input  logic signed [IN_WIDTH-1:0]  score,
    output logic                        score_ready,
    output logic                        busy,
    output logic                        done,
    output logic        [IDX_WIDTH-1:0] class_idx,
    output logic signed [IN_WIDTH-1:0]  max_score,
    input  logic        [IDX_WIDTH-1:0] rd_addr,
    output logic signed [IN_WIDTH-1:0]  rd_data
);
    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;
    localparam int DEPTH = 2 ** IDX_WIDTH;
    localparam logic [IDX_WIDTH:0] NUM_W = (IDX_WIDTH + 1)'(NUM_CLASSES);
    localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(NUM_CLASSES - 1);
    state_t                      state_q, state_d;
    logic        [IDX_WIDTH-1:0] cnt_q, cnt_d;
    logic signed [IN_WIDTH-1:0]  run_max_q, run_max_d;
    logic        [IDX_WIDTH-1:0] run_idx_q, run_idx_d;
    logic        [IDX_WIDTH-1:0] class_idx_q, class_idx_d;
    logic signed [IN_WIDTH-1:0]  max_score_q, max_score_d;
    logic                        done_q, done_d;
    logic signed [IN_WIDTH-1:0]  rd_data_q, rd_data_d;
    // Buffer spans the full address space; entries past NUM_CLASSES stay 0.
    logic signed [IN_WIDTH-1:0]  buf_q [DEPTH];
    logic signed [IN_WIDTH-1:0]  buf_d [DEPTH];
    logic                        accept;
    logic                        take_new;
    logic signed [IN_WIDTH-1:0]  cand_max;
    logic        [IDX_WIDTH-1:0] cand_idx;
    always_comb begin
        accept    = score_valid && (state_q == COLLECT);
        // First score always loads; later ones need a strictly greater value so ties keep the lower index.
        take_new  = (cnt_q == '0) || (score > run_max_q);
        cand_max  = take_new ? score : run_max_q;
        cand_idx  = take_new ? cnt_q : run_idx_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        run_max_d   = run_max_q;
        run_idx_d   = run_idx_q;
        class_idx_d = class_idx_q;
        max_score_d = max_score_q;
        done_d      = 1'b0;
        buf_d       = buf_q;
        if ((state_q == IDLE || state_q == DONE) && start) begin
            state_d   = COLLECT;
            cnt_d     = '0;
            run_max_d = '0;
            run_idx_d = '0;
        end
        if (accept) begin
            buf_d[cnt_q] = score;
            cnt_d        = cnt_q + 1'b1;
            run_max_d    = cand_max;
            run_idx_d    = cand_idx;
            if (cnt_q == LAST) begin
                state_d     = DONE;
                class_idx_d = cand_idx;
                max_score_d = cand_max;
                done_d      = 1'b1;
            end
        end
        rd_data_d = ({1'b0, rd_addr} < NUM_W) ? buf_q[rd_addr] : '0;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            run_max_q   <= '0;
            run_idx_q   <= '0;
            class_idx_q <= '0;
            max_score_q <= '0;
            done_q      <= 1'b0;
            rd_data_q   <= '0;
            buf_q       <= '{default: '0};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            run_max_q   <= run_max_d;
            run_idx_q   <= run_idx_d;
            class_idx_q <= class_idx_d;
            max_score_q <= max_score_d;
            done_q      <= done_d;
            rd_data_q   <= rd_data_d;
            buf_q       <= buf_d;
        end
    end
    assign score_ready = (state_q == COLLECT);
    assign busy        = (state_q == COLLECT);
    assign done        = done_q;
    assign class_idx   = class_idx_q;
    assign max_score   = max_score_q;
    assign rd_data     = rd_data_q;
endmodule

// File: tb/tb_fc_argmax_classifier.sv
// tb_fc_argmax_classifier: randomized and directed checks against an argmax reference model
module tb_fc_argmax_classifier;
    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               score_valid = 1'b0;
    logic signed [31:0] score = '0;
    logic               score_ready;
    logic               busy;
    logic               done;
    logic        [3:0]  class_idx;
    logic signed [31:0] max_score;
    logic        [3:0]  rd_addr = '0;
    logic signed [31:0] rd_data;
    int checks = 0;
    int errors = 0;
    logic signed [31:0] cur [10];
    logic signed [31:0] mbuf [16];
    logic        [3:0]  prev_idx = '0;
    logic signed [31:0] prev_max = '0;
    fc_argmax_classifier #(.IN_WIDTH(32), .NUM_CLASSES(10), .IDX_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .score_valid(score_valid), .score(score),
        .score_ready(score_ready), .busy(busy), .done(done), .class_idx(class_idx),
        .max_score(max_score), .rd_addr(rd_addr), .rd_data(rd_data)
    );
    always #5 clk = ~clk;
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    function automatic logic signed [31:0] rnd_score(input int mode);
        logic signed [31:0] v;
        int sel;
        if (mode == 0) v = $urandom;
        else if (mode == 1) v = $signed($urandom_range(0, 6)) - 3;
        else begin
            sel = $urandom_range(0, 3);
            v = (sel == 0) ? 32'sh80000000 : (sel == 1) ? 32'sh7fffffff : (sel == 2) ? 32'sh0 : -32'sd1;
        end
        return v;
    endfunction
    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; score_valid = 1'b0; rd_addr = '0;
        tick();
        checks += 6;
        if (score_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b want 0", score_ready); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done); end
        if (class_idx !== 4'd0) begin errors++; $display("FAIL reset_class_idx: got %0d want 0", class_idx); end
        if (max_score !== 32'sd0) begin errors++; $display("FAIL reset_max_score: got %0d want 0", max_score); end
        if (rd_data !== 32'sd0) begin errors++; $display("FAIL reset_rd_data: got %0d want 0", rd_data); end
        rst_n = 1'b1;
        prev_idx = '0;
        prev_max = '0;
        for (int i = 0; i < 16; i++) mbuf[i] = '0;
    endtask
    task automatic test_readback;
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            tick();
            checks++;
            if (rd_data !== mbuf[a]) begin errors++; $display("FAIL readback[%0d]: got %0d want %0d", a, rd_data, mbuf[a]); end
        end
    endtask
    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks += 2;
        if (busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %0b want 1", busy); end
        if (score_ready !== 1'b1) begin errors++; $display("FAIL start_ready: got %0b want 1", score_ready); end
    endtask
    // stall_mode: 0 back-to-back, 1 valid every other cycle, 2 random gaps; poke drives start during collection
    task automatic collect(input int stall_mode, input bit poke);
        int k;
        int cyc;
        bit v;
        logic [3:0] ra;
        logic [3:0] eidx;
        logic signed [31:0] emax;
        k = 0;
        cyc = 0;
        while (k < 10 && cyc < 200) begin
            v = (stall_mode == 0) ? 1'b1 : (stall_mode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
            score_valid = v;
            score = v ? cur[k] : $urandom;
            start = poke;
            ra = 4'(k);
            rd_addr = ra;
            tick();
            cyc++;
            checks++;
            if (rd_data !== mbuf[ra]) begin errors++; $display("FAIL rw_same_entry[%0d]: got %0d want %0d", ra, rd_data, mbuf[ra]); end
            if (v) k++;
            if (k < 10) begin
                checks += 5;
                if (busy !== 1'b1) begin errors++; $display("FAIL collect_busy: got %0b want 1", busy); end
                if (score_ready !== 1'b1) begin errors++; $display("FAIL collect_ready: got %0b want 1", score_ready); end
                if (done !== 1'b0) begin errors++; $display("FAIL early_done at accept %0d: got %0b want 0", k, done); end
                if (class_idx !== prev_idx) begin errors++; $display("FAIL hold_class_idx: got %0d want %0d", class_idx, prev_idx); end
                if (max_score !== prev_max) begin errors++; $display("FAIL hold_max_score: got %0d want %0d", max_score, prev_max); end
            end
        end
        score_valid = 1'b0;
        start = 1'b0;
        eidx = 4'd0;
        emax = cur[0];
        for (int i = 1; i < 10; i++) if (cur[i] > emax) begin emax = cur[i]; eidx = 4'(i); end
        for (int i = 0; i < 10; i++) mbuf[i] = cur[i];
        checks += 5;
        if (done !== 1'b1) begin errors++; $display("FAIL done_pulse: got %0b want 1", done); end
        if (busy !== 1'b0) begin errors++; $display("FAIL done_busy: got %0b want 0", busy); end
        if (score_ready !== 1'b0) begin errors++; $display("FAIL done_ready: got %0b want 0", score_ready); end
        if (class_idx !== eidx) begin errors++; $display("FAIL class_idx: got %0d want %0d", class_idx, eidx); end
        if (max_score !== emax) begin errors++; $display("FAIL max_score: got %0d want %0d", max_score, emax); end
        prev_idx = eidx;
        prev_max = emax;
    endtask
    task automatic test_after_done;
        tick();
        checks += 4;
        if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %0b want 0", done); end
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_done_busy: got %0b want 0", busy); end
        if (class_idx !== prev_idx) begin errors++; $display("FAIL post_done_class_idx: got %0d want %0d", class_idx, prev_idx); end
        if (max_score !== prev_max) begin errors++; $display("FAIL post_done_max_score: got %0d want %0d", max_score, prev_max); end
    endtask
    task automatic test_basic;
        cur = '{3, -7, 25, 0, 12, 25, -1, 8, 9, 4};
        do_start();
        collect(0, 1'b0);
        test_after_done();
        test_readback();
    endtask
    task automatic test_negative_stalls;
        cur = '{-100, -50, 32'sh80000000, -51, -3, -900, -4, -60, -70, -80};
        do_start();
        collect(1, 1'b0);
        test_after_done();
    endtask
    task automatic test_extreme_last;
        for (int i = 0; i < 9; i++) cur[i] = '0;
        cur[9] = 32'sh7fffffff;
        do_start();
        collect(0, 1'b1);
        test_after_done();
    endtask
    task automatic test_reset_mid;
        for (int i = 0; i < 10; i++) cur[i] = rnd_score(0);
        do_start();
        for (int i = 0; i < 5; i++) begin
            score_valid = 1'b1;
            score = cur[i];
            tick();
        end
        score_valid = 1'b0;
        rd_addr = 4'd1;
        rst_n = 1'b0;
        tick();
        checks += 6;
        if (score_ready !== 1'b0) begin errors++; $display("FAIL midreset_ready: got %0b want 0", score_ready); end
        if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %0b want 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL midreset_done: got %0b want 0", done); end
        if (class_idx !== 4'd0) begin errors++; $display("FAIL midreset_class_idx: got %0d want 0", class_idx); end
        if (max_score !== 32'sd0) begin errors++; $display("FAIL midreset_max_score: got %0d want 0", max_score); end
        if (rd_data !== 32'sd0) begin errors++; $display("FAIL midreset_rd_data: got %0d want 0", rd_data); end
        rst_n = 1'b1;
        prev_idx = '0;
        prev_max = '0;
        for (int i = 0; i < 16; i++) mbuf[i] = '0;
        test_readback();
        for (int i = 0; i < 3; i++) begin
            score_valid = 1'b1;
            score = rnd_score(0);
            tick();
            checks++;
            if (score_ready !== 1'b0) begin errors++; $display("FAIL idle_ready: got %0b want 0", score_ready); end
        end
        score_valid = 1'b0;
        test_readback();
        for (int i = 0; i < 10; i++) cur[i] = rnd_score(1);
        do_start();
        collect(0, 1'b0);
        test_after_done();
    endtask
    task automatic test_illegal_done;
        for (int i = 0; i < 4; i++) begin
            score_valid = 1'b1;
            score = rnd_score(0);
            tick();
            checks += 3;
            if (score_ready !== 1'b0) begin errors++; $display("FAIL done_state_ready: got %0b want 0", score_ready); end
            if (done !== 1'b0) begin errors++; $display("FAIL done_state_pulse: got %0b want 0", done); end
            if (class_idx !== prev_idx) begin errors++; $display("FAIL done_state_hold: got %0d want %0d", class_idx, prev_idx); end
        end
        score_valid = 1'b0;
        test_readback();
    endtask
    task automatic test_back_to_back;
        for (int i = 0; i < 10; i++) cur[i] = rnd_score(2);
        do_start();
        collect(0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        checks += 2;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %0b want 1", busy); end
        if (class_idx !== prev_idx) begin errors++; $display("FAIL b2b_hold: got %0d want %0d", class_idx, prev_idx); end
        for (int i = 0; i < 10; i++) cur[i] = i + 1;
        collect(0, 1'b0);
        test_after_done();
    endtask
    task automatic test_random;
        for (int n = 0; n < 25; n++) begin
            int mode;
            mode = $urandom_range(0, 2);
            for (int i = 0; i < 10; i++) cur[i] = rnd_score(mode);
            do_start();
            collect($urandom_range(0, 2), 1'($urandom_range(0, 1)));
            test_after_done();
            if (n % 8 == 0) test_readback();
        end
    endtask
    initial begin
        test_reset();
        test_basic();
        test_illegal_done();
        test_negative_stalls();
        test_extreme_last();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
